// File: rtl/oven_pkg.sv
// oven_pkg: display states, set-mode codes and segment patterns shared by the oven display
package oven_pkg;
  typedef enum logic [1:0] {
    SHOW_CLOCK = 2'd0,
    SHOW_TIMER = 2'd1,
    SHOW_END   = 2'd2
  } disp_state_t;
  localparam logic [1:0] SET_NONE  = 2'd0;
  localparam logic [1:0] SET_HOURS = 2'd1;
  localparam logic [1:0] SET_MINS  = 2'd2;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;
  localparam logic [0:6] SEG_DASH  = 7'b1111110;
  localparam logic [0:6] SEG_E     = 7'b0110000;
  localparam logic [0:6] SEG_N     = 7'b1101010;
  localparam logic [0:6] SEG_D     = 7'b1000010;
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: 4-bit BCD to active-low segments a..g, dash for non-decimal codes
module bcd_to_seg7
  import oven_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [0:6] seg
);
  always_comb begin
    case (bcd)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/oven_display_ctrl.sv
// oven_display_ctrl: selects clock, timer or "End" for four active-low 7-segment digits,
// with set-mode blinking, leading-zero blanking and a timed end message
module oven_display_ctrl
  import oven_pkg::*;
#(
  parameter int CLK_HZ   = 50000000,
  parameter int BLINK_HZ = 2,
  parameter int END_SECS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] min1,
  input  logic [3:0] min2,
  input  logic [3:0] hr1,
  input  logic [3:0] hr2,
  input  logic [3:0] tmr_sec1,
  input  logic [3:0] tmr_sec2,
  input  logic [3:0] tmr_min1,
  input  logic [3:0] tmr_min2,
  input  logic       timer_running,
  input  logic       show_timer,
  input  logic       timer_done,
  input  logic       ack,
  input  logic [1:0] set_mode,
  output logic [0:6] Hex0,
  output logic [0:6] Hex1,
  output logic [0:6] Hex2,
  output logic [0:6] Hex3,
  output logic [1:0] disp_state
);
  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int BW = HALF > 1 ? $clog2(HALF) : 1;
  localparam int END_CYC = END_SECS * CLK_HZ;
  localparam int EW = END_CYC > 1 ? $clog2(END_CYC) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(HALF - 1);
  localparam logic [EW-1:0] END_LAST = EW'(END_CYC - 1);
  disp_state_t state, nxt;
  logic [BW-1:0] blink_cnt;
  logic blink_phase;
  logic [EW-1:0] end_cnt;
  logic [3:0] d3, d2, d1, d0;
  logic [0:6] s3, s2, s1, s0, n3, n2, n1, n0;
  logic tv, is_end, blank_hi, blank_lo;
  always_comb begin
    nxt = timer_done ? SHOW_END :
          state == SHOW_END ? ((ack || end_cnt == END_LAST) ? SHOW_CLOCK : SHOW_END) :
          (timer_running || show_timer) ? SHOW_TIMER : SHOW_CLOCK;
  end
  // Display content follows the state being entered so Hex and disp_state agree
  assign tv = nxt == SHOW_TIMER;
  assign is_end = nxt == SHOW_END;
  assign d3 = tv ? tmr_min2 : hr2;
  assign d2 = tv ? tmr_min1 : hr1;
  assign d1 = tv ? tmr_sec2 : min2;
  assign d0 = tv ? tmr_sec1 : min1;
  bcd_to_seg7 u_dec3 (.bcd(d3), .seg(s3));
  bcd_to_seg7 u_dec2 (.bcd(d2), .seg(s2));
  bcd_to_seg7 u_dec1 (.bcd(d1), .seg(s1));
  bcd_to_seg7 u_dec0 (.bcd(d0), .seg(s0));
  assign blank_hi = nxt == SHOW_CLOCK && set_mode == SET_HOURS && blink_phase;
  assign blank_lo = nxt == SHOW_CLOCK && set_mode == SET_MINS && blink_phase;
  assign n3 = (is_end || blank_hi || d3 == 4'd0) ? SEG_BLANK : s3;
  assign n2 = is_end ? SEG_E : blank_hi ? SEG_BLANK : s2;
  assign n1 = is_end ? SEG_N : blank_lo ? SEG_BLANK : s1;
  assign n0 = is_end ? SEG_D : blank_lo ? SEG_BLANK : s0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SHOW_CLOCK;
      disp_state  <= 2'(SHOW_CLOCK);
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      end_cnt     <= '0;
      Hex3        <= SEG_BLANK;
      Hex2        <= SEG_BLANK;
      Hex1        <= SEG_BLANK;
      Hex0        <= SEG_BLANK;
    end else begin
      state       <= nxt;
      disp_state  <= 2'(nxt);
      blink_cnt   <= blink_cnt == BLINK_LAST ? '0 : blink_cnt + 1'b1;
      blink_phase <= blink_phase ^ (blink_cnt == BLINK_LAST);
      end_cnt     <= (state == SHOW_END && nxt == SHOW_END && !timer_done) ? end_cnt + 1'b1 : '0;
      Hex3        <= n3;
      Hex2        <= n2;
      Hex1        <= n1;
      Hex0        <= n0;
    end
  end
endmodule

// File: doc/oven_display_ctrl.md
Name: oven_display_ctrl

Overview:
- Output stage downstream of the oven time-of-day counter and the cook timer.
- Takes the BCD clock digits (hours:minutes) and the timer digits (minutes:seconds), picks what to show, and drives four active-low seven-segment displays.
- Adds set-mode digit blinking, leading-zero blanking and a timed "End" message when cooking completes.
- All display outputs are registered.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz
BLINK_HZ, 2, blink rate in full on/off cycles per second; phase toggles every CLK_HZ/(2*BLINK_HZ) cycles
END_SECS, 5, duration of the "End" message in seconds

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
min1, min2, hr1, hr2  in  4 each  clock BCD digits: minute units, minute tens, hour units, hour tens
tmr_sec1, tmr_sec2, tmr_min1, tmr_min2  in  4 each  cook-timer BCD digits
timer_running  in  1  level; cook timer is counting
show_timer  in  1  level; user request to view the timer
timer_done  in  1  single-cycle pulse; countdown reached zero
ack  in  1  single-cycle pulse; user key press that dismisses "End"
set_mode  in  2  0 = none, 1 = editing hours, 2 = editing minutes, 3 = treated as 0
Hex0, Hex1, Hex2, Hex3  out  [0:6] each  segments a..g, active-low; Hex0 is the rightmost digit
disp_state  out  2  current state, for debug

Behaviour:
- Decided: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: all Hex = 1111111 (blank); state SHOW_CLOCK; blink counter 0; blink_phase 0; end counter 0.
- Reset asserted mid-operation blanks the displays in the same cycle and abandons any "End" message.
- Latency: inputs are sampled on the clk edge; Hex updates on that same edge (1 cycle).
- States:
  - SHOW_CLOCK (0): displays hr2 hr1 min2 min1 on Hex3..Hex0.
  - SHOW_TIMER (1): displays tmr_min2 tmr_min1 tmr_sec2 tmr_sec1.
  - SHOW_END (2): Hex3 blank, Hex2 'E', Hex1 'n', Hex0 'd'.
- Transitions:
  - SHOW_CLOCK -> SHOW_TIMER when timer_running or show_timer.
  - SHOW_TIMER -> SHOW_CLOCK when neither is high.
  - Any state -> SHOW_END on timer_done; end counter cleared.
  - SHOW_END -> SHOW_CLOCK when the end counter reaches END_SECS*CLK_HZ-1, or on ack.
- Priority: timer_done beats ack in the same cycle (enter or restart SHOW_END). timer_done while already in SHOW_END restarts the counter.
- Blink counter: free-running from reset, width $clog2(CLK_HZ/(2*BLINK_HZ)). At terminal count it wraps to 0 and toggles blink_phase.
- Set mode, applied in SHOW_CLOCK only:
  - set_mode=1 blanks Hex3/Hex2 while blink_phase=1.
  - set_mode=2 blanks Hex1/Hex0 while blink_phase=1.
  - The non-edited pair stays steady.
- Leading-zero blanking:
  - hr2==0 in SHOW_CLOCK blanks Hex3.
  - tmr_min2==0 in SHOW_TIMER blanks Hex3.
  - No other digits are blanked.
- Decoding:
  - Digit values 10..15 display '-' (1111110).
  - Encodings [a..g]: 0=0000001, 1=1001111, 2=0010010, 5=0100100, 8=0000000, E=0110000, n=1101010, d=1000010.

Decomposition:
- Shared package oven_pkg holds:
  - the display state enum (SHOW_CLOCK, SHOW_TIMER, SHOW_END);
  - the set_mode encodings;
  - segment constants SEG_BLANK, SEG_DASH, SEG_E, SEG_N, SEG_D.
- One natural sub-module: bcd_to_seg7, a pure combinational 4-bit to [0:6] active-low decoder with '-' for invalid input. Instantiate it four times; blanking and muxing happen ahead of the output registers.

Test Plan (CLK_HZ=8, BLINK_HZ=1, END_SECS=2: phase toggles every 4 cycles, "End" lasts 16 cycles):
1. Reset and basic display: rst_n low -> all Hex 1111111. Release, clock 12:05 -> next edge Hex3=1001111, Hex2=0010010, Hex1=0000001, Hex0=0100100.
2. Leading zero and invalid digit: 09:41 -> Hex3 blank. min1=4'hC -> Hex0=1111110.
3. Set-mode blink: set_mode=1 with 12:05 -> Hex3/Hex2 alternate digit/blank every 4 cycles; Hex1/Hex0 steady. set_mode=2 -> minutes blink instead.
4. Timer view: timer_running=1 with timer 03:27 -> Hex3 blank, then 3, 2, 7; disp_state=1. Drop timer_running -> clock returns next cycle.
5. End message: timer_done pulse -> "End" held 16 cycles, then clock. Repeat with ack at cycle 5 -> clock at cycle 6. timer_done and ack in the same cycle -> SHOW_END with a full 16 cycles.
6. Reset mid-"End": assert rst_n at cycle 8 of SHOW_END -> immediate blank. After release -> SHOW_CLOCK with no residual "End".
